rl_force_eval_unit_tagged: RTL and testbench
============================================

Name: rl_force_eval_unit_tagged

Overview:
- Parametrised successor to the range-limited force evaluation unit. Instantiates filter_bank and RL_LJ_Evaluate_Pairs_1st_Order_normalized.
- Each accepted pair carries a full metadata tag (neighbor full ID, reference cell ID, reference particle ID) down a delay line whose depth is a parameter. The tag arrives exactly aligned with the force.
- A reference-switch FSM drains the filters and the force pipeline before a new reference particle ID is accepted.
- Sits between the pair-generation FSM and the force accumulators / force caches.

Parameters:
- NUM_FILTER, md_pkg::NUM_FILTER, number of filter channels.
- FORCE_LATENCY, 14, cycles from filter_bank out_valid to force pipeline LJ_force_valid.
- CNT_W, $clog2(FORCE_LATENCY+2), in-flight counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- phase  in  1  passed to filter_bank
- pair_valid  in  NUM_FILTER  per-filter pair valid
- ref_particle_id  in  particle_id_t  current reference particle
- nb_particle_id  in  particle_id_t  neighbor particle
- ref_pos  in  data_tuple_t[NUM_FILTER]  reference positions
- nb_pos  in  data_tuple_t  neighbor position
- out_ref_particle_id  out  full_id_t  {ref cell ID, ref particle ID} of the emitted force
- out_neighbor_particle_id  out  full_id_t  neighbor full ID
- out_rl_force  out  data_tuple_t  pair force
- out_force_valid  out  1  force/tag valid
- out_back_pressure  out  NUM_FILTER  per-filter stall to upstream
- out_all_buffer_empty  out  1  filter buffers empty AND nothing in flight
- out_ref_switch_done  out  1  one-cycle pulse when a new reference ID becomes active
- out_err  out  2  sticky; [0] tag/force misalignment, [1] pair offered while not RUN

Behaviour:
- Reset: all outputs 0 and every delay-line stage invalid.
  - active_ref_id = 0, inflight = 0, state = RUN.
  - Reset mid-operation discards all in-flight pairs; the force pipeline is reset too.
- Pair gating: filter_bank.input_valid = pair_valid when state == RUN, else 0.
  - pair_valid != 0 while state != RUN sets out_err[1]; that pair is dropped.
- Tag capture: on filter_bank out_valid, push {1, nb_id_out, ref_cell_id_out, active_ref_id} into stage 0.
  - The delay line is FORCE_LATENCY stages deep and shifts every cycle; invalid entries shift too.
  - Stage FORCE_LATENCY-1 drives out_neighbor_particle_id and out_ref_particle_id.
  - out_force_valid = LJ_force_valid.
  - If LJ_force_valid differs from the tag valid bit in that cycle, set out_err[0]. Outputs still follow the force pipeline.
  - Total latency from filter out_valid to output is exactly FORCE_LATENCY cycles.
- In-flight counter:
  - +1 on filter out_valid, -1 on LJ_force_valid; both in the same cycle leaves it unchanged.
  - Saturates at 2^CNT_W-1 and at 0; never wraps.
- FSM states and transitions:
  - RUN -> DRAIN when ref_particle_id != active_ref_id.
  - DRAIN -> SWITCH when filter all_buffer_empty = 1, inflight = 0, and filter out_valid = 0 in the same cycle.
  - SWITCH (1 cycle): active_ref_id <= ref_particle_id, out_ref_switch_done = 1, then -> RUN.
  - If ref_particle_id changes again during DRAIN, stay in DRAIN; SWITCH latches the value present in the SWITCH cycle.
  - If ref_particle_id returns to active_ref_id during DRAIN, SWITCH still executes (drain completes, pulse issued).
- out_back_pressure = filter back_pressure OR {NUM_FILTER{state != RUN}}.
- out_all_buffer_empty = filter all_buffer_empty AND inflight == 0. Registered-free combinational AND.
- Force parameters p_a / p_b / p_qq are constants 2.0 / 4.0 / 8.0 in IEEE-754 single precision.

Decomposition:
- md_pkg holds NUM_FILTER, particle_id_t, full_id_t, full_cell_id_t, data_tuple_t, and a new rl_tag_t struct {valid, nb_id, ref_cell_id, ref_id}.
- One natural sub-module: rl_tag_delay_line. Parameters DEPTH and type rl_tag_t; synchronous reset clears all valid bits.

Test Plan:
- Single pair: pair on filter 0, nb_id 5, active ref 3 -> exactly one out_force_valid, FORCE_LATENCY cycles after filter out_valid. Output has neighbor ID 5, ref particle ID 3, out_err = 0.
- Back-to-back: 20 consecutive pairs with nb_id 0..19 -> 20 outputs in order, no gaps beyond the filter pattern, inflight peaks at ≤ FORCE_LATENCY+1 and returns to 0.
- Reference switch: ref_particle_id changes 3 -> 7 with 4 pairs in flight -> out_back_pressure = all ones until drained. The 4 outputs carry ref 3, then a done pulse, then the next pairs carry ref 7.
- Protocol violation: pair_valid = 1 during DRAIN -> pair absent at output, out_err[1] set and stays set until rst.
- Reset mid-flight: rst for 1 cycle with 6 pairs in flight -> no out_force_valid afterwards, inflight = 0, state = RUN, outputs 0.
- Parameter sweep: FORCE_LATENCY = 17 with a matching force pipeline -> alignment holds and out_err[0] stays 0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types for the range-limited force path: particle/cell IDs, position
// tuples, the per-pair metadata tag and the reference-switch FSM states.
package md_pkg;
  localparam int NUM_FILTER    = 4;
  localparam int PARTICLE_ID_W = 8;
  localparam int CELL_ID_W     = 9;
  localparam int DATA_W        = 32;

  typedef logic [PARTICLE_ID_W-1:0] particle_id_t;
  typedef logic [CELL_ID_W-1:0]     full_cell_id_t;

  typedef struct packed {
    full_cell_id_t cell_id;
    particle_id_t  particle_id;
  } full_id_t;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] z;
  } data_tuple_t;

  typedef struct packed {
    logic          valid;
    full_id_t      nb_id;
    full_cell_id_t ref_cell_id;
    particle_id_t  ref_id;
  } rl_tag_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } rl_state_t;

  // LJ parameters 2.0 / 4.0 / 8.0 as IEEE-754 single precision
  localparam logic [DATA_W-1:0] P_A  = 32'h4000_0000;
  localparam logic [DATA_W-1:0] P_B  = 32'h4080_0000;
  localparam logic [DATA_W-1:0] P_QQ = 32'h4100_0000;

  // Home cell (2,2,2); filter channel n serves the reference cell home+n
  localparam full_cell_id_t HOME_CELL = 9'o222;

  function automatic full_cell_id_t filter_cell_id(input int unsigned idx);
    return HOME_CELL + full_cell_id_t'(idx);
  endfunction
endpackage

// File: rtl/RL_LJ_Evaluate_Pairs_1st_Order_normalized.sv
// Fixed-latency force pipeline stand-in: force = (ref - nb) + {p_a, p_b, p_qq},
// emitted exactly LATENCY cycles after input_valid.
module RL_LJ_Evaluate_Pairs_1st_Order_normalized
  import md_pkg::*;
#(
  parameter int LATENCY = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              input_valid,
  input  data_tuple_t       ref_pos,
  input  data_tuple_t       nb_pos,
  input  logic [DATA_W-1:0] p_a,
  input  logic [DATA_W-1:0] p_b,
  input  logic [DATA_W-1:0] p_qq,
  output data_tuple_t       LJ_force,
  output logic              LJ_force_valid
);
  data_tuple_t        force_r [LATENCY];
  logic [LATENCY-1:0] valid_r;

  // Compute in stage 0, then carry through the remaining stages
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) force_r[i] <= '0;
    end else begin
      valid_r[0]   <= input_valid;
      force_r[0].x <= ref_pos.x - nb_pos.x + p_a;
      force_r[0].y <= ref_pos.y - nb_pos.y + p_b;
      force_r[0].z <= ref_pos.z - nb_pos.z + p_qq;
      for (int i = 1; i < LATENCY; i++) begin
        valid_r[i] <= valid_r[i-1];
        force_r[i] <= force_r[i-1];
      end
    end
  end

  assign LJ_force       = force_r[LATENCY-1];
  assign LJ_force_valid = valid_r[LATENCY-1];
endmodule

// File: rtl/filter_bank.sv
// Per-channel pair FIFOs with a single arbitrated output port; phase selects
// which end of the channel list wins arbitration.
module filter_bank
  import md_pkg::*;
#(
  parameter int NUM_FILTER = md_pkg::NUM_FILTER,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         phase,
  input  logic [NUM_FILTER-1:0]        input_valid,
  input  particle_id_t                 nb_particle_id,
  input  data_tuple_t [NUM_FILTER-1:0] ref_pos,
  input  data_tuple_t                  nb_pos,
  output logic                         out_valid,
  output full_id_t                     nb_id_out,
  output full_cell_id_t                ref_cell_id_out,
  output data_tuple_t                  ref_pos_out,
  output data_tuple_t                  nb_pos_out,
  output logic [NUM_FILTER-1:0]        back_pressure,
  output logic                         all_buffer_empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int IDX_W = (NUM_FILTER > 1) ? $clog2(NUM_FILTER) : 1;

  typedef struct packed {
    particle_id_t nb_id;
    data_tuple_t  nb_pos;
    data_tuple_t  ref_pos;
  } fb_entry_t;

  fb_entry_t          mem_r    [NUM_FILTER][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r [NUM_FILTER];
  logic [PTR_W-1:0]   rd_ptr_r [NUM_FILTER];
  logic [CW-1:0]      count_r  [NUM_FILTER];
  logic [NUM_FILTER-1:0] push_s, pop_s, nonempty_s;
  logic               sel_valid_s;
  logic [IDX_W-1:0]   sel_idx_s;
  fb_entry_t          sel_entry_s;
  logic               out_valid_r;
  full_id_t           nb_id_r;
  full_cell_id_t      ref_cell_r;
  data_tuple_t        ref_pos_r, nb_pos_r;

  // Channel status; a full channel silently drops, upstream honours back_pressure
  always_comb begin
    nonempty_s    = '0;
    push_s        = '0;
    back_pressure = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      nonempty_s[i]    = (count_r[i] != CW'(0));
      push_s[i]        = input_valid[i] && (count_r[i] != CW'(FIFO_DEPTH));
      back_pressure[i] = (count_r[i] >= CW'(FIFO_DEPTH - 1));
    end
  end

  // Fixed-priority arbitration whose direction follows phase
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      if (!sel_valid_s && nonempty_s[phase ? (NUM_FILTER - 1 - i) : i]) begin
        sel_valid_s = 1'b1;
        sel_idx_s   = IDX_W'(phase ? (NUM_FILTER - 1 - i) : i);
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Pop strobe for the winning channel
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      pop_s[i] = sel_valid_s && (sel_idx_s == IDX_W'(i));
    end
  end

  assign sel_entry_s      = mem_r[sel_idx_s][rd_ptr_r[sel_idx_s]];
  assign all_buffer_empty = (nonempty_s == '0);

  // FIFO storage
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FILTER; i++) begin
      if (push_s[i]) mem_r[i][wr_ptr_r[i]] <= '{nb_id: nb_particle_id, nb_pos: nb_pos, ref_pos: ref_pos[i]};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FILTER; i++) begin
      if (rst) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        count_r[i]  <= '0;
      end else begin
        if (push_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
        if (pop_s[i])  rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CW'(1);
          2'b01:   count_r[i] <= count_r[i] - CW'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  // Registered output port
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      nb_id_r     <= '0;
      ref_cell_r  <= '0;
      ref_pos_r   <= '0;
      nb_pos_r    <= '0;
    end else begin
      out_valid_r <= sel_valid_s;
      if (sel_valid_s) begin
        nb_id_r    <= '{cell_id: HOME_CELL, particle_id: sel_entry_s.nb_id};
        ref_cell_r <= filter_cell_id(32'(sel_idx_s));
        ref_pos_r  <= sel_entry_s.ref_pos;
        nb_pos_r   <= sel_entry_s.nb_pos;
      end
    end
  end

  assign out_valid       = out_valid_r;
  assign nb_id_out       = nb_id_r;
  assign ref_cell_id_out = ref_cell_r;
  assign ref_pos_out     = ref_pos_r;
  assign nb_pos_out      = nb_pos_r;
endmodule

// File: rtl/rl_tag_delay_line.sv
// Shift register carrying pair metadata alongside the force pipeline; every
// stage shifts each cycle, invalid entries included.
module rl_tag_delay_line
  import md_pkg::*;
#(
  parameter int  DEPTH = 14,
  parameter type tag_t = rl_tag_t
) (
  input  logic clk,
  input  logic rst,
  input  tag_t in_tag,
  output tag_t out_tag
);
  tag_t stage_r [DEPTH];

  // Reset clears whole entries so the ID outputs read zero as well
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
    end else begin
      stage_r[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign out_tag = stage_r[DEPTH-1];
endmodule

// File: rtl/rl_force_eval_unit_tagged.sv
// Range-limited force evaluation with per-pair metadata tags aligned to the
// force output, plus a drain-then-switch FSM for reference particle changes.
module rl_force_eval_unit_tagged
  import md_pkg::*;
#(
  parameter int NUM_FILTER    = md_pkg::NUM_FILTER,
  parameter int FORCE_LATENCY = 14,
  parameter int CNT_W         = $clog2(FORCE_LATENCY + 2)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         phase,
  input  logic [NUM_FILTER-1:0]        pair_valid,
  input  particle_id_t                 ref_particle_id,
  input  particle_id_t                 nb_particle_id,
  input  data_tuple_t [NUM_FILTER-1:0] ref_pos,
  input  data_tuple_t                  nb_pos,
  output full_id_t                     out_ref_particle_id,
  output full_id_t                     out_neighbor_particle_id,
  output data_tuple_t                  out_rl_force,
  output logic                         out_force_valid,
  output logic [NUM_FILTER-1:0]        out_back_pressure,
  output logic                         out_all_buffer_empty,
  output logic                         out_ref_switch_done,
  output logic [1:0]                   out_err
);
  rl_state_t             state_r;
  particle_id_t          active_ref_id_r;
  logic [CNT_W-1:0]      inflight_r;
  logic [1:0]            err_r;
  logic                  switch_done_r;
  logic [NUM_FILTER-1:0] fb_in_valid_s, fb_bp_s;
  logic                  fb_out_valid_s, fb_empty_s, lj_valid_s;
  full_id_t              fb_nb_id_s;
  full_cell_id_t         fb_ref_cell_s;
  data_tuple_t           fb_ref_pos_s, fb_nb_pos_s, lj_force_s;
  rl_tag_t               tag_in_s, tag_out_s;

  assign fb_in_valid_s = (state_r == ST_RUN) ? pair_valid : '0;

  filter_bank #(.NUM_FILTER(NUM_FILTER)) u_filter_bank (
    .clk(clk), .rst(rst), .phase(phase),
    .input_valid(fb_in_valid_s), .nb_particle_id(nb_particle_id),
    .ref_pos(ref_pos), .nb_pos(nb_pos),
    .out_valid(fb_out_valid_s), .nb_id_out(fb_nb_id_s),
    .ref_cell_id_out(fb_ref_cell_s), .ref_pos_out(fb_ref_pos_s),
    .nb_pos_out(fb_nb_pos_s), .back_pressure(fb_bp_s),
    .all_buffer_empty(fb_empty_s)
  );

  RL_LJ_Evaluate_Pairs_1st_Order_normalized #(.LATENCY(FORCE_LATENCY)) u_force (
    .clk(clk), .rst(rst), .input_valid(fb_out_valid_s),
    .ref_pos(fb_ref_pos_s), .nb_pos(fb_nb_pos_s),
    .p_a(P_A), .p_b(P_B), .p_qq(P_QQ),
    .LJ_force(lj_force_s), .LJ_force_valid(lj_valid_s)
  );

  // active_ref_id only changes with the pipeline empty, so it is safe to sample here
  assign tag_in_s = '{valid: fb_out_valid_s, nb_id: fb_nb_id_s,
                      ref_cell_id: fb_ref_cell_s, ref_id: active_ref_id_r};

  rl_tag_delay_line #(.DEPTH(FORCE_LATENCY), .tag_t(rl_tag_t)) u_tag_line (
    .clk(clk), .rst(rst), .in_tag(tag_in_s), .out_tag(tag_out_s)
  );

  // Saturating count of pairs between filter output and force output
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= '0;
    end else begin
      case ({fb_out_valid_s, lj_valid_s})
        2'b10:   if (inflight_r != {CNT_W{1'b1}}) inflight_r <= inflight_r + CNT_W'(1);
        2'b01:   if (inflight_r != CNT_W'(0))     inflight_r <= inflight_r - CNT_W'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Reference-switch FSM; the done pulse is high for the SWITCH cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_RUN;
      active_ref_id_r <= '0;
      switch_done_r   <= 1'b0;
    end else begin
      switch_done_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (ref_particle_id != active_ref_id_r) state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fb_empty_s && (inflight_r == CNT_W'(0)) && !fb_out_valid_s) begin
            state_r       <= ST_SWITCH;
            switch_done_r <= 1'b1;
          end
        end
        ST_SWITCH: begin
          active_ref_id_r <= ref_particle_id;
          state_r         <= ST_RUN;
        end
        default: state_r <= ST_RUN;
      endcase
    end
  end

  // Sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 2'b00;
    end else begin
      if (lj_valid_s != tag_out_s.valid) err_r[0] <= 1'b1;
      if ((pair_valid != '0) && (state_r != ST_RUN)) err_r[1] <= 1'b1;
    end
  end

  assign out_force_valid          = lj_valid_s;
  assign out_rl_force             = lj_force_s;
  assign out_neighbor_particle_id = tag_out_s.nb_id;
  assign out_ref_particle_id      = '{cell_id: tag_out_s.ref_cell_id, particle_id: tag_out_s.ref_id};
  assign out_back_pressure        = fb_bp_s | {NUM_FILTER{state_r != ST_RUN}};
  assign out_all_buffer_empty     = fb_empty_s & (inflight_r == CNT_W'(0));
  assign out_ref_switch_done      = switch_done_r;
  assign out_err                  = err_r;
endmodule

// File: tb/tb_rl_force_eval_unit_tagged.sv
// Scoreboard bench: stimulus pushes expected {nb ID, ref ID, force}; a negedge
// monitor pops and compares for the default unit and a FORCE_LATENCY=17 copy.
module tb_rl_force_eval_unit_tagged;
  import md_pkg::*;

  localparam int NF   = md_pkg::NUM_FILTER;
  localparam int LAT  = 14;
  localparam int LAT2 = 17;
  localparam logic [31:0] PA = 32'h4000_0000, PB = 32'h4080_0000, PQ = 32'h4100_0000;
  localparam logic [8:0]  HOME = 9'o222;

  typedef struct packed { full_id_t nb; full_id_t rf; data_tuple_t f; } exp_t;

  logic clk = 1'b0;
  logic rst, phase;
  logic [NF-1:0] pair_valid;
  particle_id_t ref_particle_id, nb_particle_id;
  data_tuple_t [NF-1:0] ref_pos;
  data_tuple_t nb_pos;

  full_id_t o_ref, o_nb, o_ref2, o_nb2;
  data_tuple_t o_force, o_force2;
  logic o_valid, o_valid2, o_empty, o_empty2, o_done, o_done2;
  logic [NF-1:0] o_bp, o_bp2;
  logic [1:0] o_err, o_err2;

  exp_t sb_q[$], sb2_q[$];
  exp_t mon_e, mon_e2;
  int checks = 0, errors = 0;
  int out_count = 0, out_count2 = 0, done_pulses = 0, done_pulses2 = 0, q_at_switch = -1;
  particle_id_t exp_ref = '0;
  int lat;

  always #5 clk = ~clk;

  rl_force_eval_unit_tagged #(.FORCE_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .phase(phase), .pair_valid(pair_valid),
    .ref_particle_id(ref_particle_id), .nb_particle_id(nb_particle_id),
    .ref_pos(ref_pos), .nb_pos(nb_pos),
    .out_ref_particle_id(o_ref), .out_neighbor_particle_id(o_nb),
    .out_rl_force(o_force), .out_force_valid(o_valid), .out_back_pressure(o_bp),
    .out_all_buffer_empty(o_empty), .out_ref_switch_done(o_done), .out_err(o_err)
  );

  rl_force_eval_unit_tagged #(.FORCE_LATENCY(LAT2)) dut2 (
    .clk(clk), .rst(rst), .phase(phase), .pair_valid(pair_valid),
    .ref_particle_id(ref_particle_id), .nb_particle_id(nb_particle_id),
    .ref_pos(ref_pos), .nb_pos(nb_pos),
    .out_ref_particle_id(o_ref2), .out_neighbor_particle_id(o_nb2),
    .out_rl_force(o_force2), .out_force_valid(o_valid2), .out_back_pressure(o_bp2),
    .out_all_buffer_empty(o_empty2), .out_ref_switch_done(o_done2), .out_err(o_err2)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pop and compare whenever either unit presents a force
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      out_count++;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out actual nb=%0h required no output", o_nb);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_lat14", {o_nb, o_ref, o_force}, mon_e);
      end
    end
    if (o_valid2 === 1'b1) begin
      out_count2++;
      if (sb2_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out17 actual nb=%0h required no output", o_nb2);
      end else begin
        mon_e2 = sb2_q.pop_front();
        chk("out_lat17", {o_nb2, o_ref2, o_force2}, mon_e2);
      end
    end
    if (o_done === 1'b1) begin
      done_pulses++;
      q_at_switch = sb_q.size();
    end
    if (o_done2 === 1'b1) done_pulses2++;
  end

  // One pair for one cycle on filter f; called just after a rising edge
  task automatic send(input int f, input int nb);
    exp_t e;
    pair_valid     = '0;
    pair_valid[f]  = 1'b1;
    nb_particle_id = particle_id_t'(nb);
    nb_pos.x = 32'(nb * 3);
    nb_pos.y = 32'(nb + 100);
    nb_pos.z = 32'd7;
    ref_pos[f].x = 32'(1000 + f * 16);
    ref_pos[f].y = 32'd2000;
    ref_pos[f].z = 32'(nb * 5);
    e.nb  = '{cell_id: HOME, particle_id: particle_id_t'(nb)};
    e.rf  = '{cell_id: HOME + 9'(f), particle_id: exp_ref};
    e.f.x = 32'(1000 + f * 16) - 32'(nb * 3) + PA;
    e.f.y = 32'd2000 - 32'(nb + 100) + PB;
    e.f.z = 32'(nb * 5) - 32'd7 + PQ;
    sb_q.push_back(e);
    sb2_q.push_back(e);
    @(posedge clk); #1;
    pair_valid = '0;
  endtask

  task automatic wait_switch(input string name, input int budget);
    int s1, s2;
    s1 = done_pulses;
    s2 = done_pulses2;
    for (int i = 0; i < budget; i++) begin
      if (done_pulses != s1 && done_pulses2 != s2) break;
      @(posedge clk);
    end
    #1;
    checks++;
    if (done_pulses == s1 || done_pulses2 == s2) begin
      errors++;
      $display("FAIL %s pulses=%0d/%0d required %0d/%0d", name, done_pulses, done_pulses2, s1 + 1, s2 + 1);
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0 && sb2_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0 || sb2_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d/%0d required 0/0", name, sb_q.size(), sb2_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; phase = 1'b0; pair_valid = '0;
    ref_particle_id = '0; nb_particle_id = '0; ref_pos = '0; nb_pos = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 160'(o_valid), 160'(0));
    chk("reset_err", 160'(o_err), 160'(0));
    chk("reset_bp", 160'(o_bp), 160'(0));
    chk("reset_empty", 160'(o_empty), 160'(1));
    chk("reset_ids_force", {o_nb, o_ref, o_force, o_done}, 160'(0));

    // Switch from reset reference 0 to 3
    @(posedge clk); #1 ref_particle_id = 8'd3;
    @(posedge clk); #1;
    chk("drain_bp_0to3", 160'(o_bp), 160'({NF{1'b1}}));
    wait_switch("switch_0to3", 60);
    exp_ref = 8'd3;
    chk("run_bp", 160'(o_bp), 160'(0));

    // Single pair: total latency = filter register + FORCE_LATENCY
    send(0, 5);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (o_valid === 1'b1) begin lat = n; break; end
    end
    chk("single_latency", 160'(lat), 160'(LAT + 1));
    wait_empty("single_drain", 60);
    chk("single_err", 160'(o_err), 160'(0));

    // Twenty back-to-back pairs across the channels
    for (int i = 0; i < 20; i++) send(i % NF, i);
    wait_empty("b2b_drain", 200);
    chk("b2b_empty", {o_empty, o_empty2}, 160'(3));
    chk("b2b_err", {o_err, o_err2}, 160'(0));

    // Four in flight, then switch 3 -> 7 and offer an illegal pair during DRAIN
    for (int i = 0; i < 4; i++) send(i, 40 + i);
    ref_particle_id = 8'd7;
    @(posedge clk); #1;
    chk("drain_bp_3to7", {o_bp, o_bp2}, 160'({2 * NF{1'b1}}));
    pair_valid = 4'b0001; nb_particle_id = 8'd99;
    @(posedge clk); #1 pair_valid = '0;
    chk("drain_bp_hold", 160'(o_bp), 160'({NF{1'b1}}));
    wait_switch("switch_3to7", 120);
    chk("drained_before_switch", 160'(q_at_switch), 160'(0));
    exp_ref = 8'd7;
    chk("err_protocol", {o_err, o_err2}, {156'(0), 4'b1010});
    send(1, 60);
    send(2, 61);
    wait_empty("post_switch_drain", 80);
    chk("err_sticky", {o_err, o_err2}, {156'(0), 4'b1010});

    // Reset with six pairs in flight
    for (int i = 0; i < 6; i++) send(i % NF, 70 + i);
    rst = 1'b1; ref_particle_id = '0;
    @(posedge clk); #1 rst = 1'b0;
    sb_q.delete();
    sb2_q.delete();
    chk("midrst_bp", {o_bp, o_bp2}, 160'(0));
    chk("midrst_outs", {o_valid, o_err, o_nb, o_ref, o_force, o_done}, 160'(0));
    chk("midrst_empty", {o_empty, o_empty2}, 160'(3));
    repeat (40) @(posedge clk);
    #1;
    chk("count_lat14", 160'(out_count), 160'(27));
    chk("count_lat17", 160'(out_count2), 160'(27));
    chk("final_err", {o_err, o_err2}, 160'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
